mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port byte-addressed data RAM (12-bit address space, big-endian byte order, one-hot size write-enable, combinational read).
- Requester I: instruction fetch, read-only, word-sized.
- Requester D: load/store unit, read/write, byte/half/word.
- Round-robin arbitration; alignment and range checking; every access runs as one registered RAM cycle followed by one response cycle.

---
 rtl/mem_arbiter_pkg.sv | 38 +++
 rtl/mem_access_check.sv | 26 ++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the data-RAM arbiter: access sizes, one-hot RAM write enables
// and sequencer states, plus small helpers that map a size onto byte count and enable.
package mem_arbiter_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    localparam logic [2:0] WE_WORD = 3'b001;
    localparam logic [2:0] WE_HALF = 3'b010;
    localparam logic [2:0] WE_BYTE = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    function automatic logic [2:0] sizeBytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: sizeBytes = 3'd1;
            SIZE_HALF: sizeBytes = 3'd2;
            SIZE_WORD: sizeBytes = 3'd4;
            default:   sizeBytes = 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] weOneHot(input logic [1:0] size);
        case (size)
            SIZE_BYTE: weOneHot = WE_BYTE;
            SIZE_HALF: weOneHot = WE_HALF;
            SIZE_WORD: weOneHot = WE_WORD;
            default:   weOneHot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_check.sv
// Combinational legality check for one access: illegal size, misalignment, or
// running past the end of the RAM (evaluated in 33 bits so large addresses cannot wrap).
module mem_access_check
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_LIMIT = 4096
) (
    input  logic [31:0] addr_i,
    input  logic [1:0]  size_i,
    output logic        err_o
);

    logic [32:0] endAddr;
    logic        misaligned;

    always_comb begin
        endAddr = {1'b0, addr_i} + {30'b0, sizeBytes(size_i)};
        case (size_i)
            SIZE_WORD: misaligned = (addr_i[1:0] != 2'b00);
            SIZE_HALF: misaligned = addr_i[0];
            default:   misaligned = 1'b0;
        endcase
        err_o = (size_i == SIZE_ILLEGAL) || misaligned || (endAddr > 33'(ADDR_LIMIT));
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch (I) and load/store (D) for the single-port
// data RAM; each granted access takes one registered RAM cycle and one response cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_LIMIT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [2:0]  ram_write_enable,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_data_in,
    input  logic [31:0] ram_data_out
);

    state_t      state_q;
    logic        lastD_q;
    logic        ownerD_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic        i_rvalid_q, d_rvalid_q;
    logic        i_err_q, d_err_q;
    logic [31:0] i_rdata_q, d_rdata_q;
    logic [31:0] rdata_d;

    logic        canGrant, pickD, grantI, grantD, selErr;
    logic [31:0] selAddr;
    logic [1:0]  selSize;

    // On a tie the requester that was not served last wins; lastD_q resets to "I served".
    assign canGrant = !reset && ((state_q == IDLE) || (state_q == RESP));
    assign pickD    = d_req && (!i_req || !lastD_q);
    assign grantD   = canGrant && pickD;
    assign grantI   = canGrant && i_req && !pickD;
    assign selAddr  = grantD ? d_addr : i_addr;
    assign selSize  = grantD ? d_size : SIZE_WORD;

    mem_access_check #(.ADDR_LIMIT(ADDR_LIMIT)) u_check (
        .addr_i (selAddr),
        .size_i (selSize),
        .err_o  (selErr)
    );

    always_comb begin
        rdata_d = 32'h0;
        if (!err_q && !we_q) begin
            case (size_q)
                SIZE_BYTE: rdata_d = {24'h0, ram_data_out[31:24]};
                SIZE_HALF: rdata_d = {16'h0, ram_data_out[31:16]};
                default:   rdata_d = ram_data_out;
            endcase
        end
    end

    // Decoded from state so that an asynchronous reset removes the enable at once.
    assign ram_write_enable = ((state_q == ACCESS) && we_q && !err_q) ? weOneHot(size_q) : 3'b000;
    assign ram_addr         = addr_q;
    assign ram_data_in      = wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            lastD_q    <= 1'b0;
            ownerD_q   <= 1'b0;
            addr_q     <= 32'h0;
            size_q     <= SIZE_BYTE;
            we_q       <= 1'b0;
            wdata_q    <= 32'h0;
            err_q      <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
            i_rdata_q  <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
            case (state_q)
                IDLE, RESP: begin
                    if (grantI || grantD) begin
                        state_q  <= ACCESS;
                        ownerD_q <= grantD;
                        lastD_q  <= grantD;
                        addr_q   <= selAddr;
                        size_q   <= selSize;
                        we_q     <= grantD && d_we;
                        wdata_q  <= grantD ? d_wdata : 32'h0;
                        err_q    <= selErr;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    state_q <= RESP;
                    if (ownerD_q) begin
                        d_rvalid_q <= 1'b1;
                        d_rdata_q  <= rdata_d;
                        d_err_q    <= err_q;
                    end else begin
                        i_rvalid_q <= 1'b1;
                        i_rdata_q  <= rdata_d;
                        i_err_q    <= err_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i_gnt    = grantI;
    assign d_gnt    = grantD;
    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign i_err    = i_err_q;
    assign d_err    = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a byte-array RAM on the RAM port, a reference
// memory model for expected responses, directed scenarios and a randomized access mix.
module tb_mem_arbiter;

    logic        clk, reset;
    logic        i_req, i_gnt, i_rvalid, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [2:0]  ram_write_enable;
    logic [31:0] ram_addr, ram_data_in, ram_data_out;

    logic [7:0]  ramMem [0:4095];
    logic [7:0]  refMem [0:4095];
    logic [11:0] a0, a1, a2, a3;
    int          checks = 0;
    int          failures = 0;
    int          writeCount = 0;
    int          bothGnt = 0;
    logic [2:0]  lastWe = 3'b000;

    mem_arbiter #(.ADDR_LIMIT(4096)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .ram_write_enable(ram_write_enable), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Big-endian byte RAM with combinational read and one-hot sized writes.
    assign a0 = ram_addr[11:0];
    assign a1 = a0 + 12'd1;
    assign a2 = a0 + 12'd2;
    assign a3 = a0 + 12'd3;
    assign ram_data_out = {ramMem[a0], ramMem[a1], ramMem[a2], ramMem[a3]};

    always @(posedge clk) begin
        if (!reset && ram_write_enable != 3'b000) begin
            writeCount <= writeCount + 1;
            lastWe <= ram_write_enable;
            case (ram_write_enable)
                3'b001: begin
                    ramMem[a0] <= ram_data_in[31:24];
                    ramMem[a1] <= ram_data_in[23:16];
                    ramMem[a2] <= ram_data_in[15:8];
                    ramMem[a3] <= ram_data_in[7:0];
                end
                3'b010: begin
                    ramMem[a0] <= ram_data_in[15:8];
                    ramMem[a1] <= ram_data_in[7:0];
                end
                3'b100: ramMem[a0] <= ram_data_in[7:0];
                default: ;
            endcase
        end
    end

    always @(negedge clk) if (i_gnt && d_gnt) bothGnt <= bothGnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference model: access legality, memory effect and returned data from plain arithmetic.
    task automatic modelAccess(input bit isD, input bit we, input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, output bit expErr, output logic [31:0] expData,
                               output logic [2:0] expWe);
        int     nBytes;
        longint lastByte;
        logic [1:0] sz;
        sz = isD ? size : 2'b10;
        nBytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
        lastByte = longint'(addr) + nBytes;
        expErr = (sz == 2'b11) || (addr % nBytes != 0) || (lastByte > 4096);
        expData = 32'h0;
        expWe = 3'b000;
        if (!expErr && isD && we) begin
            for (int k = 0; k < nBytes; k++)
                refMem[addr + k] = 8'((wdata >> (8 * (nBytes - 1 - k))) & 32'hFF);
            expWe = (nBytes == 1) ? 3'b100 : (nBytes == 2) ? 3'b010 : 3'b001;
        end else if (!expErr) begin
            for (int k = 0; k < nBytes; k++)
                expData = (expData << 8) | {24'h0, refMem[addr + k]};
        end
    endtask

    // Issues one request at a negedge and follows it through gnt, ACCESS and the response pulse.
    task automatic applyStimulus(input bit isD, input bit we, input logic [1:0] size, input logic [31:0] addr,
                                 input logic [31:0] wdata, input string tag);
        bit         expErr;
        logic [31:0] expData;
        logic [2:0] expWe;
        int         startWrites, waited;
        modelAccess(isD, we, size, addr, wdata, expErr, expData, expWe);
        startWrites = writeCount;
        if (isD) begin
            d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        #1;
        waited = 0;
        while (!(isD ? d_gnt : i_gnt) && waited < 20) begin
            @(negedge clk); #1; waited++;
        end
        checkOutput({tag, ".gnt"}, 32'(isD ? d_gnt : i_gnt), 32'd1);
        checkOutput({tag, ".otherGnt"}, 32'(isD ? i_gnt : d_gnt), 32'd0);
        if (waited >= 20) begin
            i_req = 1'b0; d_req = 1'b0;
            return;
        end
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk); #1;
        checkOutput({tag, ".rvalid"}, 32'(isD ? d_rvalid : i_rvalid), 32'd1);
        checkOutput({tag, ".otherRvalid"}, 32'(isD ? i_rvalid : d_rvalid), 32'd0);
        checkOutput({tag, ".rdata"}, isD ? d_rdata : i_rdata, expData);
        checkOutput({tag, ".err"}, 32'(isD ? d_err : i_err), 32'(expErr));
        checkOutput({tag, ".writes"}, 32'(writeCount - startWrites), (expWe != 3'b000) ? 32'd1 : 32'd0);
        if (expWe != 3'b000) checkOutput({tag, ".we"}, 32'(lastWe), 32'(expWe));
        @(negedge clk); #1;
        checkOutput({tag, ".rvalidPulse"}, 32'(isD ? d_rvalid : i_rvalid), 32'd0);
    endtask

    task automatic doReset();
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int       grants, cycles;
        bit       order [0:7];
        int       writesBefore;
        logic [31:0] addr;
        logic [1:0]  size;
        for (int k = 0; k < 4096; k++) begin ramMem[k] = 8'h00; refMem[k] = 8'h00; end
        i_addr = 32'h0; d_we = 1'b0; d_size = 2'b00; d_addr = 32'h0; d_wdata = 32'h0;
        doReset();
        reset = 1'b1;
        #1;
        checkOutput("reset.gnt", {30'h0, i_gnt, d_gnt}, 32'd0);
        checkOutput("reset.rvalid", {30'h0, i_rvalid, d_rvalid}, 32'd0);
        checkOutput("reset.err", {30'h0, i_err, d_err}, 32'd0);
        checkOutput("reset.irdata", i_rdata, 32'd0);
        checkOutput("reset.drdata", d_rdata, 32'd0);
        checkOutput("reset.we", 32'(ram_write_enable), 32'd0);
        checkOutput("reset.ramAddr", ram_addr, 32'd0);
        checkOutput("reset.ramDataIn", ram_data_in, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(1, 1, 2'b10, 32'h10, 32'hDEADBEEF, "preloadFetch");
        applyStimulus(0, 0, 2'b10, 32'h10, 32'h0, "fetch10");
        checkOutput("fetch10.value", i_rdata, 32'hDEADBEEF);
        applyStimulus(1, 1, 2'b00, 32'h103, 32'h000000A5, "storeByte");
        applyStimulus(1, 0, 2'b10, 32'h100, 32'h0, "loadWord100");
        checkOutput("loadWord100.value", d_rdata, 32'h000000A5);
        applyStimulus(1, 1, 2'b01, 32'h200, 32'h00001234, "storeHalf");
        applyStimulus(1, 0, 2'b00, 32'h201, 32'h0, "loadByte201");
        checkOutput("loadByte201.value", d_rdata, 32'h00000034);
        applyStimulus(1, 0, 2'b01, 32'h200, 32'h0, "loadHalf200");
        checkOutput("loadHalf200.value", d_rdata, 32'h00001234);

        applyStimulus(1, 0, 2'b10, 32'h102, 32'h0, "errMisWord");
        applyStimulus(1, 0, 2'b01, 32'hFFF, 32'h0, "errRangeHalf");
        applyStimulus(1, 0, 2'b11, 32'h0, 32'h0, "errSize");
        applyStimulus(1, 1, 2'b10, 32'hFFC, 32'h01020304, "storeTop");
        applyStimulus(1, 1, 2'b10, 32'hFFE, 32'h05060708, "errStoreFFE");
        applyStimulus(1, 0, 2'b10, 32'hFFC, 32'h0, "loadTop");
        applyStimulus(0, 0, 2'b10, 32'hFFFFFFFC, 32'h0, "fetchWrap");

        // Both requesters held from reset: grants must alternate starting with D.
        doReset();
        i_req = 1'b1; i_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h4;
        grants = 0; cycles = 0;
        while (grants < 8 && cycles < 100) begin
            #1;
            if (d_gnt) begin order[grants] = 1'b1; grants++; end
            else if (i_gnt) begin order[grants] = 1'b0; grants++; end
            @(negedge clk);
            cycles++;
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("contention.count", 32'(grants), 32'd8);
        for (int k = 0; k < grants; k++)
            checkOutput($sformatf("contention.order%0d", k), 32'(order[k]), 32'((k % 2) == 0));

        // Reset during the ACCESS cycle of a store must suppress the write.
        applyStimulus(1, 1, 2'b10, 32'h40, 32'h11223344, "preload40");
        writesBefore = writeCount;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h40; d_wdata = 32'hCAFEF00D;
        #1;
        checkOutput("midReset.gnt", 32'(d_gnt), 32'd1);
        @(negedge clk); #1;
        checkOutput("midReset.weBefore", 32'(ram_write_enable), 32'd1);
        reset = 1'b1; d_req = 1'b0;
        #1;
        checkOutput("midReset.weAfter", 32'(ram_write_enable), 32'd0);
        checkOutput("midReset.outs", {26'h0, i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err}, 32'd0);
        checkOutput("midReset.ramAddr", ram_addr, 32'd0);
        checkOutput("midReset.ramDataIn", ram_data_in, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput("midReset.writes", 32'(writeCount - writesBefore), 32'd0);
        checkOutput("midReset.mem", {ramMem[12'h40], ramMem[12'h41], ramMem[12'h42], ramMem[12'h43]}, 32'h11223344);
        applyStimulus(1, 0, 2'b10, 32'h40, 32'h0, "afterReset");

        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 3))
                0: addr = 32'($urandom_range(0, 1023));
                1: addr = 32'($urandom_range(4088, 4100));
                2: addr = $urandom;
                default: addr = 32'($urandom_range(0, 255)) << 2;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(0, 0, 2'b10, addr, 32'h0, $sformatf("rndI%0d", n));
            end else begin
                size = 2'($urandom_range(0, 3));
                applyStimulus(1, 1'($urandom_range(0, 1)), size, addr, $urandom, $sformatf("rndD%0d", n));
            end
        end

        checkOutput("gntOverlap", 32'(bothGnt), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
